// File: rtl/odd_result_pipe.sv
// Odd-pipe result pipeline: carries results DEPTH stages to write-back and
// answers forwarding/hazard lookups from the registered stages.
module odd_result_pipe #(
  parameter int DEPTH  = 7,
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7,
  parameter int LAT_W  = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_wrt_en,
  input  logic [ADDR_W-1:0] in_rt_address,
  input  logic [DATA_W-1:0] in_rt_value,
  input  logic [LAT_W-1:0]  in_latency,
  input  logic [ADDR_W-1:0] query_address,
  output logic              fwd_hit,
  output logic              fwd_stall,
  output logic [DATA_W-1:0] fwd_value,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_rt_address,
  output logic [DATA_W-1:0] wb_rt_value,
  output logic [2:0]        occupancy
);

  logic              valid_q [1:DEPTH];
  logic              wrt_q   [1:DEPTH];
  logic [ADDR_W-1:0] addr_q  [1:DEPTH];
  logic [DATA_W-1:0] val_q   [1:DEPTH];
  logic [LAT_W-1:0]  lat_q   [1:DEPTH];
  logic [2:0]        occ_q;

  logic              valid_d [1:DEPTH];
  logic              wrt_d   [1:DEPTH];
  logic [ADDR_W-1:0] addr_d  [1:DEPTH];
  logic [DATA_W-1:0] val_d   [1:DEPTH];
  logic [LAT_W-1:0]  lat_d   [1:DEPTH];
  logic [2:0]        occ_d;

  // Flush squashes the capture and every stage behind write-back in one edge.
  always_comb begin
    valid_d[1] = in_valid & ~flush;
    wrt_d[1]   = in_wrt_en;
    addr_d[1]  = in_rt_address;
    val_d[1]   = in_rt_value;
    lat_d[1]   = (in_latency == '0) ? LAT_W'(1) : in_latency;
    for (int k = 2; k <= DEPTH; k++) begin
      valid_d[k] = valid_q[k-1] & ~flush;
      wrt_d[k]   = wrt_q[k-1];
      addr_d[k]  = addr_q[k-1];
      val_d[k]   = val_q[k-1];
      lat_d[k]   = lat_q[k-1];
    end
    occ_d = '0;
    for (int k = 1; k <= DEPTH - 1; k++) begin
      occ_d = occ_d + 3'(valid_d[k]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        wrt_q[k]   <= 1'b0;
        addr_q[k]  <= '0;
        val_q[k]   <= '0;
        lat_q[k]   <= '0;
      end
      occ_q <= '0;
    end else begin
      for (int k = 1; k <= DEPTH; k++) begin
        valid_q[k] <= valid_d[k];
        wrt_q[k]   <= wrt_d[k];
        addr_q[k]  <= addr_d[k];
        val_q[k]   <= val_d[k];
        lat_q[k]   <= lat_d[k];
      end
      occ_q <= occ_d;
    end
  end

  // Scan oldest to youngest so the youngest match overrides any older one.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_value = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (valid_q[k] && wrt_q[k] && (addr_q[k] == query_address)) begin
        if (k >= int'(lat_q[k])) begin
          fwd_hit   = 1'b1;
          fwd_stall = 1'b0;
          fwd_value = val_q[k];
        end else begin
          fwd_hit   = 1'b0;
          fwd_stall = 1'b1;
          fwd_value = '0;
        end
      end
    end
  end

  assign wb_valid      = valid_q[DEPTH] & wrt_q[DEPTH];
  assign wb_rt_address = addr_q[DEPTH];
  assign wb_rt_value   = val_q[DEPTH];
  assign occupancy     = occ_q;

endmodule

// File: tb/tb_odd_result_pipe.sv
// Bench for odd_result_pipe: directed scenarios plus random traffic, all
// checked against a transaction-age model of the pipeline.
module tb_odd_result_pipe;
  localparam int DEPTH  = 7;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 7;
  localparam int LAT_W  = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_wrt_en = 1'b0;
  logic [ADDR_W-1:0] in_rt_address = '0;
  logic [DATA_W-1:0] in_rt_value = '0;
  logic [LAT_W-1:0]  in_latency = '0;
  logic [ADDR_W-1:0] query_address = '0;
  logic              fwd_hit, fwd_stall, wb_valid;
  logic [DATA_W-1:0] fwd_value, wb_rt_value;
  logic [ADDR_W-1:0] wb_rt_address;
  logic [2:0]        occupancy;

  odd_result_pipe #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LAT_W(LAT_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_wrt_en(in_wrt_en), .in_rt_address(in_rt_address),
    .in_rt_value(in_rt_value), .in_latency(in_latency), .query_address(query_address),
    .fwd_hit(fwd_hit), .fwd_stall(fwd_stall), .fwd_value(fwd_value),
    .wb_valid(wb_valid), .wb_rt_address(wb_rt_address), .wb_rt_value(wb_rt_value),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  // Each in-flight result with its age in edges since capture.
  typedef struct {
    logic              wrt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                lat;
    int                age;
  } ent_t;
  ent_t mdl[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    ent_t e;
    ent_t nq[$];
    if (reset || flush) begin
      mdl.delete();
      return;
    end
    foreach (mdl[i]) begin
      e = mdl[i];
      e.age++;
      if (e.age <= DEPTH) nq.push_back(e);
    end
    if (in_valid) begin
      e.wrt  = in_wrt_en;
      e.addr = in_rt_address;
      e.data = in_rt_value;
      e.lat  = (in_latency == 0) ? 1 : int'(in_latency);
      e.age  = 1;
      nq.push_back(e);
    end
    mdl = nq;
  endtask

  task automatic check_state(input logic [ADDR_W-1:0] q);
    logic              eh, es, ewb;
    logic [DATA_W-1:0] ev, ewv;
    logic [ADDR_W-1:0] ewa;
    int best, occ;
    query_address = q;
    #1;
    eh = 1'b0; es = 1'b0; ev = '0; ewb = 1'b0; ewa = '0; ewv = '0;
    best = DEPTH + 1; occ = 0;
    foreach (mdl[i]) begin
      if (mdl[i].age <= DEPTH - 1) occ++;
      if (mdl[i].age == DEPTH && mdl[i].wrt) begin
        ewb = 1'b1; ewa = mdl[i].addr; ewv = mdl[i].data;
      end
      if (mdl[i].wrt && mdl[i].addr == q && mdl[i].age < best) begin
        best = mdl[i].age;
        eh = (mdl[i].age >= mdl[i].lat);
        es = ~eh;
        ev = eh ? mdl[i].data : '0;
      end
    end
    check("fwd_hit", DATA_W'(fwd_hit), DATA_W'(eh));
    check("fwd_stall", DATA_W'(fwd_stall), DATA_W'(es));
    check("fwd_value", fwd_value, ev);
    check("wb_valid", DATA_W'(wb_valid), DATA_W'(ewb));
    if (ewb) begin
      check("wb_addr", DATA_W'(wb_rt_address), DATA_W'(ewa));
      check("wb_value", wb_rt_value, ewv);
    end
    check("occupancy", DATA_W'(occupancy), DATA_W'(occ));
  endtask

  task automatic cycle();
    logic [ADDR_W-1:0] tq;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    if (mdl.size() > 0) tq = mdl[$urandom_range(0, mdl.size() - 1)].addr;
    else tq = ADDR_W'($urandom_range(0, 15));
    check_state(tq);
    check_state(ADDR_W'($urandom_range(0, 15)));
  endtask

  task automatic drive(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [LAT_W-1:0] l, input logic f);
    in_valid = v; in_wrt_en = w; in_rt_address = a; in_rt_value = d; in_latency = l; flush = f;
    cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    // Reset state
    #12;
    check_state(7'd5);
    check("rst_wb_addr", DATA_W'(wb_rt_address), '0);
    check("rst_wb_value", wb_rt_value, '0);
    @(negedge clock);
    reset = 1'b0;

    // Single result, latency 4
    drive(1'b1, 1'b1, 7'd5, 128'h14, 3'd4, 1'b0);
    query_address = 7'd5; #1;
    check("t1_stall_s1", DATA_W'(fwd_stall), DATA_W'(1));
    idle(3);
    query_address = 7'd5; #1;
    check("t1_hit_s4", DATA_W'(fwd_hit), DATA_W'(1));
    check("t1_val_s4", fwd_value, 128'h14);
    idle(3);
    check("t1_wb", DATA_W'(wb_valid), DATA_W'(1));
    check("t1_wb_addr", DATA_W'(wb_rt_address), DATA_W'(5));
    idle(1);

    // Youngest wins
    drive(1'b1, 1'b1, 7'd9, 128'hA, 3'd1, 1'b0);
    idle(1);
    drive(1'b1, 1'b1, 7'd9, 128'hB, 3'd4, 1'b0);
    query_address = 7'd9; #1;
    check("yw_stall", DATA_W'(fwd_stall), DATA_W'(1));
    check("yw_nohit", DATA_W'(fwd_hit), DATA_W'(0));
    idle(3);
    query_address = 7'd9; #1;
    check("yw_hit", DATA_W'(fwd_hit), DATA_W'(1));
    check("yw_val", fwd_value, 128'hB);
    idle(8);

    // Non-writing entry
    drive(1'b1, 1'b0, 7'd3, 128'h33, 3'd2, 1'b0);
    query_address = 7'd3; #1;
    check("nw_hit", DATA_W'(fwd_hit), DATA_W'(0));
    check("nw_stall", DATA_W'(fwd_stall), DATA_W'(0));
    check("nw_occ", DATA_W'(occupancy), DATA_W'(1));
    idle(6);
    check("nw_wb", DATA_W'(wb_valid), DATA_W'(0));
    idle(2);

    // Flush while rt=1 sits at write-back
    for (int i = 1; i <= 7; i++)
      drive(1'b1, 1'b1, ADDR_W'(i), DATA_W'(i * 16), LAT_W'($urandom_range(1, 7)), 1'b0);
    check("fl_wb_before", DATA_W'(wb_valid), DATA_W'(1));
    check("fl_wb_addr", DATA_W'(wb_rt_address), DATA_W'(1));
    drive(1'b1, 1'b1, 7'd8, 128'h80, 3'd1, 1'b1);
    check("fl_occ", DATA_W'(occupancy), DATA_W'(0));
    check("fl_wb_after", DATA_W'(wb_valid), DATA_W'(0));
    idle(8);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 4; i++)
      drive(1'b1, 1'b1, 7'd12, DATA_W'(i + 100), 3'd1, 1'b0);
    in_valid = 1'b0; in_wrt_en = 1'b0; query_address = 7'd12;
    #1 reset = 1'b1;
    #1;
    check("ar_wb", DATA_W'(wb_valid), DATA_W'(0));
    check("ar_hit", DATA_W'(fwd_hit), DATA_W'(0));
    check("ar_stall", DATA_W'(fwd_stall), DATA_W'(0));
    check("ar_val", fwd_value, '0);
    check("ar_occ", DATA_W'(occupancy), DATA_W'(0));
    check("ar_wb_addr", DATA_W'(wb_rt_address), '0);
    mdl.delete();
    @(negedge clock);
    reset = 1'b0;
    idle(10);

    // Latency 0 is treated as 1
    drive(1'b1, 1'b1, 7'd2, 128'hDEAD, 3'd0, 1'b0);
    query_address = 7'd2; #1;
    check("l0_hit", DATA_W'(fwd_hit), DATA_W'(1));
    check("l0_val", fwd_value, 128'hDEAD);
    idle(8);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 8),
            ADDR_W'($urandom_range(0, 15)),
            {$urandom, $urandom, $urandom, $urandom},
            LAT_W'($urandom_range(0, 7)),
            ($urandom_range(0, 99) < 3));
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
